// File: rtl/card_pkg.sv
// Shared constants, FSM state type and the blackjack point-value helper for
// the card dealer.
package card_pkg;

    localparam int RANKS     = 13;
    localparam int SUITS     = 4;
    localparam int DECK_SIZE = RANKS * SUITS;

    localparam logic [3:0] RANK_A = 4'd1;
    localparam logic [3:0] RANK_J = 4'd11;
    localparam logic [3:0] RANK_Q = 4'd12;
    localparam logic [3:0] RANK_K = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PROBE
    } dealer_state_t;

    // Blackjack value of a rank: ace counts 1, face cards count 10.
    function automatic logic [3:0] card_points(input logic [3:0] rank);
        if (rank >= RANK_J) begin
            return 4'd10;
        end
        return rank;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used as the
// random start-slot source for the dealer. A zero seed is replaced by 1.
module card_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state_o
);

    localparam logic [15:0] START = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Shift left and feed the tap XOR in at the bottom; escape the all-zero lock-up state.
    always_comb begin
        state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
        if (state_q == 16'h0000) begin
            state_d = 16'h0001;
        end
    end

    // Step every cycle; synchronous reset reloads the seed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/card_dealer.sv
// Deals one card per draw request from a single 52-card deck without
// replacement. The LFSR picks a start slot and a linear probe skips dealt
// cards. Optional feature macro: CARD_POINTS_EN adds the card_points output.
module card_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter bit          AUTO_RESHUFFLE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shuffle,
    input  logic       draw_req,
    output logic       busy,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic [5:0] cards_left,
    output logic       empty,
    output logic       draw_err
`ifdef CARD_POINTS_EN
    ,
    output logic [3:0] card_points
`endif
);

    localparam logic [5:0] FULL_DECK = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_SLOT = 6'(DECK_SIZE - 1);
    localparam logic [5:0] SUIT1_BASE = 6'(RANKS);
    localparam logic [5:0] SUIT2_BASE = 6'(2 * RANKS);
    localparam logic [5:0] SUIT3_BASE = 6'(3 * RANKS);

    dealer_state_t state_q;
    logic [51:0]   used_q;
    logic [5:0]    left_q;
    logic [5:0]    idx_q;
    logic [3:0]    rank_q;
    logic [1:0]    suit_q;
    logic [3:0]    card_rank_q;
    logic [1:0]    card_suit_q;
    logic          busy_q;
    logic          valid_q;
    logic          err_q;
`ifdef CARD_POINTS_EN
    logic [3:0]    points_q;
`endif

    logic [15:0] lfsr;
    logic [5:0]  loadIdx;
    logic [5:0]  suitBase;
    logic [1:0]  loadSuit;
    logic [3:0]  loadRank;

    card_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .state_o(lfsr)
    );

    // Fold the raw 6-bit LFSR slice into 0..51 and derive the slot's suit and rank by range compare.
    always_comb begin
        loadIdx = lfsr[5:0];
        if (loadIdx >= FULL_DECK) begin
            loadIdx = loadIdx - FULL_DECK;
        end
        loadSuit = 2'd0;
        suitBase = 6'd0;
        if (loadIdx >= SUIT3_BASE) begin
            loadSuit = 2'd3;
            suitBase = SUIT3_BASE;
        end else if (loadIdx >= SUIT2_BASE) begin
            loadSuit = 2'd2;
            suitBase = SUIT2_BASE;
        end else if (loadIdx >= SUIT1_BASE) begin
            loadSuit = 2'd1;
            suitBase = SUIT1_BASE;
        end
        loadRank = 4'(loadIdx - suitBase) + RANK_A;
    end

    // Dealer FSM: accept requests, load a start slot, probe for a free card, and drive registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            used_q      <= '0;
            left_q      <= FULL_DECK;
            idx_q       <= '0;
            rank_q      <= RANK_A;
            suit_q      <= '0;
            card_rank_q <= '0;
            card_suit_q <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef CARD_POINTS_EN
            points_q    <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (shuffle) begin
                        used_q <= '0;
                        left_q <= FULL_DECK;
                    end else if (draw_req) begin
                        if (left_q != 6'd0) begin
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                        end else if (AUTO_RESHUFFLE) begin
                            used_q  <= '0;
                            left_q  <= FULL_DECK;
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (shuffle) begin
                        used_q  <= '0;
                        left_q  <= FULL_DECK;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q   <= loadIdx;
                        rank_q  <= loadRank;
                        suit_q  <= loadSuit;
                        state_q <= PROBE;
                    end
                end
                PROBE: begin
                    if (shuffle) begin
                        used_q  <= '0;
                        left_q  <= FULL_DECK;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!used_q[idx_q]) begin
                        used_q[idx_q] <= 1'b1;
                        card_rank_q   <= rank_q;
                        card_suit_q   <= suit_q;
                        left_q        <= left_q - 6'd1;
                        valid_q       <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
`ifdef CARD_POINTS_EN
                        points_q      <= card_pkg::card_points(rank_q);
`endif
                    end else if (idx_q == LAST_SLOT) begin
                        idx_q  <= 6'd0;
                        rank_q <= RANK_A;
                        suit_q <= 2'd0;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                        if (rank_q == RANK_K) begin
                            rank_q <= RANK_A;
                            suit_q <= suit_q + 2'd1;
                        end else begin
                            rank_q <= rank_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign card_valid = valid_q;
    assign card_rank  = card_rank_q;
    assign card_suit  = card_suit_q;
    assign cards_left = left_q;
    assign empty      = (left_q == 6'd0);
    assign draw_err   = err_q;
`ifdef CARD_POINTS_EN
    assign card_points = points_q;
`endif

endmodule
